// File: rtl/vga_wave_pkg.sv
// Shared state type, default geometry and the Y clamp helper for the waveform plotter.
package vga_wave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EMIT
    } state_t;

    localparam int DEF_X_MAX = 159;
    localparam int DEF_Y_MAX = 119;
    localparam int LAT_W     = 3;
    localparam int CLAMP_W   = 16;

    function automatic logic [CLAMP_W-1:0] clamp_y(input logic [CLAMP_W-1:0] value,
                                                   input logic [CLAMP_W-1:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/vga_wave_plotter_if.sv
// Pixel write channel to the frame-buffer writer; fields are held stable while valid is high and ready is low.
interface vga_wave_plotter_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 8,
    parameter int COLOR_W = 12
);
    logic               pix_valid;
    logic               pix_ready;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COLOR_W-1:0] pix_color;

    modport master (
        output pix_valid,
        output pix_x,
        output pix_y,
        output pix_color,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_x,
        input  pix_y,
        input  pix_color,
        output pix_ready
    );
endinterface

// File: rtl/vga_phase_accum.sv
// Column base phase register and per-channel ROM address generation; address is combinational on the
// next base/channel so the caller can register it on the same edge it moves into READ.
module vga_phase_accum #(
    parameter int ADDR_W = 8,
    parameter int NCH    = 2,
    parameter int CH_W   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  base_clr,
    input  logic                  base_adv,
    input  logic [ADDR_W-1:0]     phase_step,
    input  logic [NCH*ADDR_W-1:0] ch_phase,
    input  logic [CH_W-1:0]       ch_sel,
    output logic [ADDR_W-1:0]     addr
);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] base_nxt;
    logic [ADDR_W-1:0] phase [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_phase
        assign phase[c] = ch_phase[c*ADDR_W +: ADDR_W];
    end

    always_comb begin
        base_nxt = base;
        if (base_clr) begin
            base_nxt = '0;
        end else if (base_adv) begin
            base_nxt = base + phase_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base <= '0;
        end else begin
            base <= base_nxt;
        end
    end

    // Sums wrap modulo 2^ADDR_W by construction.
    assign addr = base_nxt + phase[ch_sel];

endmodule

// File: rtl/vga_wave_plotter.sv
// Multi-channel waveform sweeper: one pixel per (X, channel) slot, ROM_LAT+1 cycles from READ entry to valid.
// A pending pixel is held stable until accepted; en pauses ROM latency counting but never drops a pixel.
module vga_wave_plotter
    import vga_wave_pkg::*;
#(
    parameter int X_W     = 8,
    parameter int Y_W     = 8,
    parameter int X_MAX   = DEF_X_MAX,
    parameter int Y_MAX   = DEF_Y_MAX,
    parameter int ADDR_W  = 8,
    parameter int NCH     = 2,
    parameter int ROM_LAT = 1,
    parameter int COLOR_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic                   continuous,
    input  logic [ADDR_W-1:0]      phase_step,
    input  logic [NCH*ADDR_W-1:0]  ch_phase,
    input  logic [NCH*COLOR_W-1:0] ch_color,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [Y_W-1:0]         rom_q,
    vga_wave_plotter_if.master     pix,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int                CH_W     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NCH - 1);
    localparam logic [X_W-1:0]    LAST_X   = X_W'(X_MAX);
    localparam logic [LAT_W-1:0]  LAT_DONE = LAT_W'(ROM_LAT);

    state_t              state;
    logic [X_W-1:0]      x;
    logic [CH_W-1:0]     ch;
    logic [CH_W-1:0]     ch_nxt;
    logic [LAT_W-1:0]    lat_cnt;
    logic [ADDR_W-1:0]   next_addr;
    logic                pix_valid_q;
    logic [X_W-1:0]      pix_x_q;
    logic [Y_W-1:0]      pix_y_q;
    logic [COLOR_W-1:0]  pix_color_q;
    logic [COLOR_W-1:0]  color [NCH];
    logic                start_go;
    logic                hs;
    logic                last_ch;
    logic                last_x;
    logic                base_clr;
    logic                base_adv;

    for (genvar c = 0; c < NCH; c++) begin : g_color
        assign color[c] = ch_color[c*COLOR_W +: COLOR_W];
    end

    assign start_go = (state == IDLE) && start && en;
    assign hs       = (state == EMIT) && pix_valid_q && pix.pix_ready;
    assign last_ch  = (ch == LAST_CH);
    assign last_x   = (x == LAST_X);
    assign base_clr = start_go || (hs && last_ch && last_x);
    assign base_adv = hs && last_ch && !last_x;

    always_comb begin
        ch_nxt = ch;
        if (start_go) begin
            ch_nxt = '0;
        end else if (hs) begin
            ch_nxt = last_ch ? '0 : ch + CH_W'(1);
        end
    end

    vga_phase_accum #(
        .ADDR_W (ADDR_W),
        .NCH    (NCH),
        .CH_W   (CH_W)
    ) u_phase (
        .clk        (clk),
        .rst        (rst),
        .base_clr   (base_clr),
        .base_adv   (base_adv),
        .phase_step (phase_step),
        .ch_phase   (ch_phase),
        .ch_sel     (ch_nxt),
        .addr       (next_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            x           <= '0;
            ch          <= '0;
            lat_cnt     <= '0;
            rom_addr    <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            ch         <= ch_nxt;
            case (state)
                IDLE: begin
                    if (start_go) begin
                        x        <= '0;
                        lat_cnt  <= '0;
                        rom_addr <= next_addr;
                        busy     <= 1'b1;
                        state    <= READ;
                    end
                end
                READ: begin
                    // rom_addr is held here, so rom_q stays valid across an en pause.
                    if (en) begin
                        if (lat_cnt == LAT_DONE) begin
                            pix_x_q     <= x;
                            pix_y_q     <= Y_W'(clamp_y(CLAMP_W'(rom_q), CLAMP_W'(Y_MAX)));
                            pix_color_q <= color[ch];
                            pix_valid_q <= 1'b1;
                            state       <= EMIT;
                        end else begin
                            lat_cnt <= lat_cnt + LAT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (hs) begin
                        pix_valid_q <= 1'b0;
                        lat_cnt     <= '0;
                        if (!last_ch) begin
                            rom_addr <= next_addr;
                            state    <= READ;
                        end else if (!last_x) begin
                            x        <= x + X_W'(1);
                            rom_addr <= next_addr;
                            state    <= READ;
                        end else begin
                            frame_done <= 1'b1;
                            if (continuous && en) begin
                                x        <= '0;
                                rom_addr <= next_addr;
                                state    <= READ;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pix.pix_valid = pix_valid_q;
    assign pix.pix_x     = pix_x_q;
    assign pix.pix_y     = pix_y_q;
    assign pix.pix_color = pix_color_q;

endmodule

// File: tb/tb_vga_wave_plotter.sv
// Bench for vga_wave_plotter: single-channel and dual-channel instances, each with an identity ROM
// (rom_q = address) and a queue-based scoreboard checked on every accepted pixel.
module tb_vga_wave_plotter;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        en_a, start_a, cont_a, busy_a, fd_a;
    logic [7:0]  step_a, ph_a, addr_a, q_a;
    logic [11:0] col_a;

    logic        en_b, start_b, cont_b, busy_b, fd_b;
    logic [7:0]  step_b, addr_b, q_b;
    logic [15:0] ph_b;
    logic [23:0] col_b;

    vga_wave_plotter_if #(.X_W(8), .Y_W(8), .COLOR_W(12)) pix_a ();
    vga_wave_plotter_if #(.X_W(8), .Y_W(8), .COLOR_W(12)) pix_b ();

    vga_wave_plotter #(.NCH(1), .ROM_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .start(start_a), .continuous(cont_a),
        .phase_step(step_a), .ch_phase(ph_a), .ch_color(col_a), .rom_addr(addr_a),
        .rom_q(q_a), .pix(pix_a), .busy(busy_a), .frame_done(fd_a)
    );

    vga_wave_plotter #(.NCH(2), .ROM_LAT(LAT_B)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .start(start_b), .continuous(cont_b),
        .phase_step(step_b), .ch_phase(ph_b), .ch_color(col_b), .rom_addr(addr_b),
        .rom_q(q_b), .pix(pix_b), .busy(busy_b), .frame_done(fd_b)
    );

    // Identity ROMs with the configured read latency.
    logic [7:0] pipe_a;
    logic [7:0] pipe_b [LAT_B];
    always @(posedge clk) begin
        pipe_a    <= addr_a;
        pipe_b[0] <= addr_b;
        for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign q_a = pipe_a;
    assign q_b = pipe_b[LAT_B-1];

    typedef struct {
        int x;
        int ch;
        int addr;
        int y;
        int color;
        bit last;
    } exp_t;

    exp_t q_exp_a[$];
    exp_t q_exp_b[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   fd_cnt_a = 0;
    int   fd_cnt_b = 0;
    bit   fd_pend_a = 1'b0;
    bit   fd_pend_b = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        return (v > 119) ? 119 : v;
    endfunction

    task automatic push_sweep_a();
        exp_t e;
        for (int x = 0; x < 160; x++) begin
            e.x = x; e.ch = 0; e.addr = x; e.y = clampv(x);
            e.color = 'hABC; e.last = (x == 159);
            q_exp_a.push_back(e);
        end
    endtask

    // phase_step 2, ch_phase {64, 0}, colours {0F0, F00}
    task automatic push_sweep_b();
        exp_t e;
        for (int x = 0; x < 160; x++) begin
            for (int c = 0; c < 2; c++) begin
                e.x = x; e.ch = c;
                e.addr = (2 * x + (c == 1 ? 64 : 0)) % 256;
                e.y = clampv(e.addr);
                e.color = (c == 1) ? 'h0F0 : 'hF00;
                e.last = (x == 159) && (c == 1);
                q_exp_b.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (fd_pend_a) begin
            chk("a_frame_done_pulse", int'(fd_a), 1);
            fd_pend_a = 1'b0;
        end
        if (fd_a) fd_cnt_a++;
        if (pix_a.pix_valid && pix_a.pix_ready) begin
            chk("a_pixel_expected", int'(q_exp_a.size() > 0), 1);
            if (q_exp_a.size() > 0) begin
                e = q_exp_a.pop_front();
                chk("a_pix_x", int'(pix_a.pix_x), e.x);
                chk("a_pix_y", int'(pix_a.pix_y), e.y);
                chk("a_pix_color", int'(pix_a.pix_color), e.color);
                chk("a_rom_addr", int'(addr_a), e.addr);
                fd_pend_a = e.last;
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (fd_pend_b) begin
            chk("b_frame_done_pulse", int'(fd_b), 1);
            fd_pend_b = 1'b0;
        end
        if (fd_b) fd_cnt_b++;
        if (pix_b.pix_valid && pix_b.pix_ready) begin
            chk("b_pixel_expected", int'(q_exp_b.size() > 0), 1);
            if (q_exp_b.size() > 0) begin
                e = q_exp_b.pop_front();
                chk("b_pix_x", int'(pix_b.pix_x), e.x);
                chk("b_pix_y", int'(pix_b.pix_y), e.y);
                chk("b_pix_color", int'(pix_b.pix_color), e.color);
                chk("b_rom_addr", int'(addr_b), e.addr);
                if (e.x == 3 && e.ch == 0)   chk("b_x3_ch0_addr", int'(addr_b), 6);
                if (e.x == 3 && e.ch == 1)   chk("b_x3_ch1_addr", int'(addr_b), 70);
                if (e.x == 25 && e.ch == 0)  chk("b_y_pass_50", int'(pix_b.pix_y), 50);
                if (e.x == 100 && e.ch == 0) chk("b_y_clamp_200", int'(pix_b.pix_y), 119);
                if (e.x == 97 && e.ch == 1)  chk("b_addr_wrap", int'(addr_b), 2);
                fd_pend_b = e.last;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
    endtask

    task automatic wait_idle_b(input string name, input int budget);
        int n;
        n = 0;
        while (busy_b && n < budget) begin
            tick();
            n++;
        end
        chk(name, int'(busy_b), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int n;
        int fd0;

        rst = 1'b1;
        en_a = 1'b1; start_a = 1'b0; cont_a = 1'b0; step_a = 8'd1; ph_a = 8'd0; col_a = 12'hABC;
        en_b = 1'b1; start_b = 1'b0; cont_b = 1'b0; step_b = 8'd2;
        ph_b  = {8'd64, 8'd0};
        col_b = {12'h0F0, 12'hF00};
        pix_a.pix_ready = 1'b1;
        pix_b.pix_ready = 1'b1;
        repeat (3) tick();

        chk("a_rst_valid", int'(pix_a.pix_valid), 0);
        chk("a_rst_busy", int'(busy_a), 0);
        chk("a_rst_frame_done", int'(fd_a), 0);
        chk("a_rst_rom_addr", int'(addr_a), 0);
        chk("b_rst_valid", int'(pix_b.pix_valid), 0);
        chk("b_rst_busy", int'(busy_b), 0);
        chk("b_rst_frame_done", int'(fd_b), 0);
        chk("b_rst_pix_x", int'(pix_b.pix_x), 0);
        chk("b_rst_pix_y", int'(pix_b.pix_y), 0);
        chk("b_rst_pix_color", int'(pix_b.pix_color), 0);
        rst = 1'b0;
        tick();

        // Single channel, ROM_LAT=1, full sweep
        fd0 = fd_cnt_a;
        push_sweep_a();
        pulse_start_a();
        lat = 0;
        while (!pix_a.pix_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("a_first_latency", lat, 2);
        n = 0;
        while (busy_a && n < 1000) begin
            tick();
            n++;
        end
        chk("a_busy_done", int'(busy_a), 0);
        repeat (2) tick();
        chk("a_frame_done_count", fd_cnt_a - fd0, 1);
        chk("a_queue_drained", q_exp_a.size(), 0);

        // start with en low is dropped
        en_b = 1'b0;
        pulse_start_b();
        repeat (3) tick();
        chk("b_start_no_en", int'(busy_b), 0);
        en_b = 1'b1;

        // Dual channel sweep with a 4-cycle pause in the first READ and a stall at x=10
        fd0 = fd_cnt_b;
        push_sweep_b();
        pulse_start_b();
        lat = 0;
        while (!pix_b.pix_valid && lat < 30) begin
            tick();
            lat++;
            if (lat == 1) en_b = 1'b0;
            if (lat == 3) chk("b_pause_addr_hold", int'(addr_b), 0);
            if (lat == 5) en_b = 1'b1;
        end
        chk("b_paused_latency", lat, 8);
        tick();
        chk("b_valid_drop_after_hs", int'(pix_b.pix_valid), 0);
        lat = 0;
        while (!pix_b.pix_valid && lat < 30) begin
            tick();
            lat++;
        end
        chk("b_unpaused_latency", lat, 4);

        n = 0;
        while (!(pix_b.pix_valid && pix_b.pix_x == 8'd10) && n < 300) begin
            tick();
            n++;
        end
        chk("b_stall_reached", int'(pix_b.pix_valid && pix_b.pix_x == 8'd10), 1);
        pix_b.pix_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_stall_valid", int'(pix_b.pix_valid), 1);
            chk("b_stall_x", int'(pix_b.pix_x), 10);
            chk("b_stall_y", int'(pix_b.pix_y), 20);
            chk("b_stall_color", int'(pix_b.pix_color), 'hF00);
            chk("b_stall_addr", int'(addr_b), 20);
        end
        pix_b.pix_ready = 1'b1;
        wait_idle_b("b_sweep1_done", 3000);
        repeat (2) tick();
        chk("b_sweep1_frame_done_count", fd_cnt_b - fd0, 1);
        chk("b_sweep1_queue_drained", q_exp_b.size(), 0);

        // Continuous: second sweep restarts at x=0, then continuous dropped mid-sweep
        cont_b = 1'b1;
        fd0 = fd_cnt_b;
        push_sweep_b();
        push_sweep_b();
        pulse_start_b();
        n = 0;
        while (fd_cnt_b == fd0 && n < 3000) begin
            tick();
            n++;
        end
        chk("b_cont_first_frame", fd_cnt_b - fd0, 1);
        chk("b_cont_still_busy", int'(busy_b), 1);
        repeat (20) tick();
        cont_b = 1'b0;
        wait_idle_b("b_cont_done", 3000);
        repeat (2) tick();
        chk("b_cont_frame_done_count", fd_cnt_b - fd0, 2);
        chk("b_cont_queue_drained", q_exp_b.size(), 0);

        // Reset while a pixel is pending
        push_sweep_b();
        pulse_start_b();
        n = 0;
        while (!(pix_b.pix_valid && pix_b.pix_x == 8'd5) && n < 300) begin
            tick();
            n++;
        end
        chk("b_rst_target_reached", int'(pix_b.pix_valid), 1);
        rst = 1'b1;
        #1;
        chk("b_async_rst_valid", int'(pix_b.pix_valid), 0);
        chk("b_async_rst_busy", int'(busy_b), 0);
        q_exp_b.delete();
        fd_pend_b = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Restart from x=0; extra start pulses while busy must not disturb the sweep
        fd0 = fd_cnt_b;
        push_sweep_b();
        pulse_start_b();
        repeat (37) tick();
        pulse_start_b();
        repeat (400) tick();
        pulse_start_b();
        wait_idle_b("b_restart_done", 3000);
        repeat (2) tick();
        chk("b_restart_frame_done_count", fd_cnt_b - fd0, 1);
        chk("b_restart_queue_drained", q_exp_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
